// File: rtl/fp_div_result_queue.sv
// fp_div_result_queue: registered result stage behind the single-precision divider.
// Captures quotient words with their overflow/underflow flags, classifies them as
// NaN/zero, buffers them in a small FIFO and keeps saturating event counters.
module fp_div_result_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_m,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_m,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_counts,
  output logic [CNT_WIDTH-1:0]       ovf_count,
  output logic [CNT_WIDTH-1:0]       unf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  // Each entry holds the quotient with its flags {ovf, unf, nan, zero} in the low bits.
  logic [DATA_WIDTH+3:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
  logic [CNT_WIDTH-1:0] unf_count_q, unf_count_d;

  logic       push;
  logic       pop;
  logic [7:0] in_exp;
  logic       mant_nonzero;
  logic [3:0] in_flags;

  // Handshakes, IEEE-754 classification of the incoming word and next-state logic.
  // in_ready comes from the registered count only, so a pop while full never frees a slot
  // in the same cycle; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    in_ready     = (count_q != FULL_COUNT);
    out_valid    = (count_q != '0);
    push         = in_valid & in_ready;
    pop          = out_valid & out_ready;
    in_exp       = in_m[DATA_WIDTH-2 -: 8];
    mant_nonzero = (in_m[DATA_WIDTH-10:0] != '0);
    in_flags     = {in_overflow, in_underflow,
                    (in_exp == 8'hFF) & mant_nonzero,
                    (in_exp == 8'h00) & ~mant_nonzero};

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_count_d = ovf_count_q;
    unf_count_d = unf_count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (clr_counts) begin
      ovf_count_d = '0;
      unf_count_d = '0;
    end else begin
      if (push && in_overflow  && (ovf_count_q != CNT_MAX)) ovf_count_d = ovf_count_q + 1'b1;
      if (push && in_underflow && (unf_count_q != CNT_MAX)) unf_count_d = unf_count_q + 1'b1;
    end
  end

  // Control state: pointers, occupancy and event counters, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_count_q <= '0;
      unf_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_count_q <= ovf_count_d;
      unf_count_q <= unf_count_d;
    end
  end

  // Storage is written on push only; its contents are never read while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_m, in_flags};
  end

  // Head entry is shown straight from storage, forced to zero while the queue is empty.
  always_comb begin
    out_m     = '0;
    out_flags = '0;
    if (out_valid) begin
      out_m     = mem_q[rd_ptr_q][DATA_WIDTH+3:4];
      out_flags = mem_q[rd_ptr_q][3:0];
    end
    count     = count_q;
    ovf_count = ovf_count_q;
    unf_count = unf_count_q;
  end

endmodule
